hpdmc_sdram_dpresp: RTL and testbench

//  SDRAM-side data-path responder: the memory end of the hpdmc_ddrio data path. Accepts burst

---
 rtl/hpdmc_sdram_dpresp_if.sv | 28 ++
 rtl/hpdmc_sdram_dpresp.sv | 169 ++++++++++++++++
 tb/tb_hpdmc_sdram_dpresp.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hpdmc_sdram_dpresp_if.sv
// Burst command and data-path bundle between an hpdmc data-path controller
// (master) and the SDRAM-side responder (slave).
interface hpdmc_sdram_dpresp_if #(
    parameter int DW = 32,
    parameter int AW = 6
);
    logic              cmd_valid;
    logic              cmd_write;
    logic [AW-1:0]     cmd_addr;
    logic              cmd_ready;
    logic [DW-1:0]     dq_i;
    logic [DW/8-1:0]   dqm_i;
    logic [DW-1:0]     dq_o;
    logic              dq_oe;
    logic              dqs_o;
    logic              dqs_oe;
    logic              busy;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, dq_i, dqm_i,
        input  cmd_ready, dq_o, dq_oe, dqs_o, dqs_oe, busy
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, dq_i, dqm_i,
        output cmd_ready, dq_o, dq_oe, dqs_o, dqs_oe, busy
    );
endinterface

// File: rtl/hpdmc_sdram_dpresp.sv
// SDRAM-side data-path responder: accepts burst commands, captures masked
// write bursts into an internal array and returns read bursts after CAS
// latency with strobe preamble/postamble. One beat per clock.
module hpdmc_sdram_dpresp #(
    parameter int DW = 32,
    parameter int AW = 6,
    parameter int BL = 8,
    parameter int CL = 2,
    parameter int WL = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    hpdmc_sdram_dpresp_if.slave bus
);
    localparam int LB   = $clog2(BL);
    localparam int LATW = $clog2(CL + WL + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WLAT   = 3'd1;
    localparam logic [2:0] WBURST = 3'd2;
    localparam logic [2:0] RLAT   = 3'd3;
    localparam logic [2:0] RBURST = 3'd4;
    localparam logic [2:0] POST   = 3'd5;

    logic [DW-1:0]   mem [0:(1<<AW)-1];

    logic [2:0]      state, state_n;
    logic [LB-1:0]   beat, beat_n;
    logic [LATW-1:0] lat, lat_n;
    logic [AW-1:0]   base, base_n;
    logic            post_n;
    logic            accept, last_beat;
    logic [2:0]      launch_state;
    logic [LATW-1:0] launch_lat;

    logic            cmd_ready, dq_oe, dqs_o, dqs_oe, busy;
    logic [DW-1:0]   dq_o;

    // Beat k address: sequential wrap inside the BL-aligned block.
    function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] a, input logic [LB-1:0] k);
        logic [AW-1:0] m;
        m = AW'(BL - 1);
        return (a & ~m) | ((a + AW'(k)) & m);
    endfunction

    assign accept    = bus.cmd_valid & cmd_ready;
    assign last_beat = (beat == LB'(BL - 1));

    // Where a freshly accepted command starts when latency is not bypassed.
    always_comb begin
        if (bus.cmd_write) begin
            launch_state = (WL == 1) ? WBURST : WLAT;
            launch_lat   = LATW'((WL > 1) ? WL - 2 : 0);
        end else begin
            launch_state = RLAT;
            launch_lat   = LATW'(CL - 2);
        end
    end

    // Next-state logic; post_n flags the strobe postamble cycle after a read
    // that is not followed straight away by another read burst.
    always_comb begin
        state_n = state;
        beat_n  = beat;
        lat_n   = lat;
        base_n  = base;
        post_n  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = launch_state;
                    lat_n   = launch_lat;
                    beat_n  = '0;
                    base_n  = bus.cmd_addr;
                end
            end
            WLAT: begin
                if (lat == '0) begin
                    state_n = WBURST;
                    beat_n  = '0;
                end else begin
                    lat_n = lat - 1'b1;
                end
            end
            WBURST: begin
                if (!last_beat) begin
                    beat_n = beat + 1'b1;
                end else if (accept) begin
                    state_n = bus.cmd_write ? WBURST : launch_state;
                    lat_n   = launch_lat;
                    beat_n  = '0;
                    base_n  = bus.cmd_addr;
                end else begin
                    state_n = IDLE;
                end
            end
            RLAT: begin
                if (lat == '0) begin
                    state_n = RBURST;
                    beat_n  = '0;
                end else begin
                    lat_n = lat - 1'b1;
                end
            end
            RBURST: begin
                if (!last_beat) begin
                    beat_n = beat + 1'b1;
                end else begin
                    post_n = !(accept && !bus.cmd_write);
                    if (accept) begin
                        state_n = bus.cmd_write ? launch_state : RBURST;
                        lat_n   = launch_lat;
                        beat_n  = '0;
                        base_n  = bus.cmd_addr;
                    end else begin
                        state_n = POST;
                    end
                end
            end
            POST:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Control state plus all registered outputs, derived from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            lat       <= '0;
            cmd_ready <= 1'b1;
            dq_oe     <= 1'b0;
            dqs_oe    <= 1'b0;
            dqs_o     <= 1'b0;
            busy      <= 1'b0;
            dq_o      <= '0;
        end else begin
            state     <= state_n;
            beat      <= beat_n;
            lat       <= lat_n;
            cmd_ready <= (state_n == IDLE) ||
                         (((state_n == WBURST) || (state_n == RBURST)) && (beat_n == LB'(BL - 1)));
            dq_oe     <= (state_n == RBURST);
            dqs_oe    <= ((state_n == RLAT) && (lat_n == '0)) || (state_n == RBURST) || post_n;
            dqs_o     <= (state_n == RBURST) && !beat_n[0];
            busy      <= (state_n != IDLE);
            if (state_n == RBURST)
                dq_o <= mem[beat_addr(base_n, beat_n)];
        end
    end

    // Command address latch and masked write-beat capture into the array.
    always_ff @(posedge clk) begin
        base <= base_n;
        if (state == WBURST) begin
            for (int b = 0; b < DW/8; b++) begin
                if (!bus.dqm_i[b])
                    mem[beat_addr(base, beat)][b*8 +: 8] <= bus.dq_i[b*8 +: 8];
            end
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.dq_o      = dq_o;
    assign bus.dq_oe     = dq_oe;
    assign bus.dqs_o     = dqs_o;
    assign bus.dqs_oe    = dqs_oe;
    assign bus.busy      = busy;
endmodule

// File: tb/tb_hpdmc_sdram_dpresp.sv
// Bench for hpdmc_sdram_dpresp: per-cycle vector table plus a hand-written
// asynchronous-reset-mid-read sequence.
module tb_hpdmc_sdram_dpresp;
    logic clk;
    logic rst_n;

    hpdmc_sdram_dpresp_if #(.DW(32), .AW(6)) dut_if ();

    hpdmc_sdram_dpresp #(.DW(32), .AW(6), .BL(8), .CL(2), .WL(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic        w;
        logic [5:0]  a;
        logic [31:0] d;
        logic [3:0]  m;
        logic        e_rdy;
        logic        e_oe;
        logic        e_soe;
        logic        e_so;
        logic        e_busy;
        logic [31:0] e_dq;
        string       tag;
    } vec_t;

    vec_t q[$];
    int   done_rows = 0;
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    logic [31:0] blk0 [8];
    logic [31:0] blk1 [8];
    logic [31:0] t6   [8];
    logic [31:0] rd2  [8];
    logic [31:0] rd3  [8];
    logic [3:0]  m0   [8];
    logic [3:0]  m2   [8];

    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    task automatic add(string tag, bit rdy, bit oe, bit soe, bit so, bit bsy, logic [31:0] dq);
        vec_t r;
        r.v = 1'b0; r.w = 1'b0; r.a = '0; r.d = '0; r.m = '0;
        r.e_rdy = rdy; r.e_oe = oe; r.e_soe = soe; r.e_so = so; r.e_busy = bsy;
        r.e_dq = dq; r.tag = tag;
        q.push_back(r);
    endtask

    // Idle cycle that issues a command.
    task automatic cmd(string tag, bit w, logic [5:0] a);
        vec_t r;
        add(tag, 1, 0, 0, 0, 0, '0);
        r = q[q.size()-1]; r.v = 1'b1; r.w = w; r.a = a; q[q.size()-1] = r;
    endtask

    // Put a command on the last row already queued (chain on last beat).
    task automatic chain(bit w, logic [5:0] a);
        vec_t r;
        r = q[q.size()-1]; r.v = 1'b1; r.w = w; r.a = a; q[q.size()-1] = r;
    endtask

    task automatic wbeats(string tag, logic [31:0] d [8], logic [3:0] m [8]);
        vec_t r;
        for (int k = 0; k < 8; k++) begin
            add(tag, k == 7, 0, 0, 0, 1, '0);
            r = q[q.size()-1]; r.d = d[k]; r.m = m[k]; q[q.size()-1] = r;
        end
    endtask

    task automatic rlat(string tag);
        add(tag, 0, 0, 1, 0, 1, '0);
    endtask

    task automatic rbeats(string tag, logic [31:0] e [8]);
        for (int k = 0; k < 8; k++)
            add(tag, k == 7, 1, 1, (k % 2) == 0, 1, e[k]);
    endtask

    task automatic post(string tag);
        add(tag, 0, 0, 1, 0, 1, '0);
    endtask

    task automatic run_rows();
        for (int i = done_rows; i < q.size(); i++) begin
            @(posedge clk); #1;
            chk($sformatf("row%0d_%s", i, q[i].tag),
                {27'd0, dut_if.cmd_ready, dut_if.dq_oe, dut_if.dqs_oe, dut_if.dqs_o, dut_if.busy,
                 (q[i].e_oe ? dut_if.dq_o : 32'd0)},
                {27'd0, q[i].e_rdy, q[i].e_oe, q[i].e_soe, q[i].e_so, q[i].e_busy,
                 (q[i].e_oe ? q[i].e_dq : 32'd0)});
            dut_if.cmd_valid = q[i].v;
            dut_if.cmd_write = q[i].w;
            dut_if.cmd_addr  = q[i].a;
            dut_if.dq_i      = q[i].d;
            dut_if.dqm_i     = q[i].m;
        end
        done_rows = q.size();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 8; k++) begin
            blk0[k] = 32'h11111111 * (k + 1);
            blk1[k] = 32'h11111111 * ((k + 9) % 16);
            t6[k]   = 32'hC0DE0000 + k;
            m0[k]   = 4'b0000;
            m2[k]   = (k == 0) ? 4'b0101 : 4'b1111;
        end
        rd2 = blk0;
        rd2[2] = 32'hAA33AA33;
        rd3 = '{32'h66666666, 32'h77777777, 32'h88888888, 32'h11111111,
                32'h22222222, 32'hAA33AA33, 32'h44444444, 32'h55555555};

        // 1: write block 0, read it back with preamble and postamble
        cmd("t1_wcmd", 1, 6'd0); wbeats("t1_wr", blk0, m0);
        cmd("t1_rcmd", 0, 6'd0); rlat("t1_pre"); rbeats("t1_rd", blk0); post("t1_post");
        // 2: masked rewrite of word 2 only
        cmd("t2_wcmd", 1, 6'd2);
        begin
            logic [31:0] d2 [8];
            for (int k = 0; k < 8; k++) d2[k] = 32'hAAAAAAAA;
            wbeats("t2_wr", d2, m2);
        end
        cmd("t2_rcmd", 0, 6'd0); rlat("t2_pre"); rbeats("t2_rd", rd2); post("t2_post");
        // 3: wrap inside the aligned block
        cmd("t3_rcmd", 0, 6'd5); rlat("t3_pre"); rbeats("t3_rd", rd3); post("t3_post");
        // 6: write chained to read on the last write beat
        cmd("t6_wcmd", 1, 6'd8); wbeats("t6_wr", t6, m0); chain(0, 6'd8);
        rlat("t6_pre"); rbeats("t6_rd", t6); post("t6_post");
        // 4: 16 chained write beats, then 16 chained read beats
        cmd("t4_wcmd", 1, 6'd0); wbeats("t4_wr0", blk0, m0); chain(1, 6'd8);
        wbeats("t4_wr1", blk1, m0);
        cmd("t4_rcmd", 0, 6'd0); rlat("t4_pre"); rbeats("t4_rd0", blk0); chain(0, 6'd8);
        rbeats("t4_rd1", blk1); post("t4_post");
        add("t4_idle", 1, 0, 0, 0, 0, '0);

        rst_n = 1'b0;
        dut_if.cmd_valid = 1'b0;
        dut_if.cmd_write = 1'b0;
        dut_if.cmd_addr  = '0;
        dut_if.dq_i      = '0;
        dut_if.dqm_i     = '0;
        #12;
        chk("reset_state",
            {27'd0, dut_if.cmd_ready, dut_if.dq_oe, dut_if.dqs_oe, dut_if.dqs_o, dut_if.busy, dut_if.dq_o},
            {27'd0, 5'b10000, 32'd0});
        @(negedge clk); rst_n = 1'b1;

        run_rows();

        // 5: asynchronous reset during read beat 3
        @(posedge clk); #1;
        dut_if.cmd_valid = 1'b1; dut_if.cmd_write = 1'b0; dut_if.cmd_addr = 6'd0;
        @(posedge clk); #1;
        dut_if.cmd_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("t5_beat3", {31'd0, dut_if.dq_oe, dut_if.dq_o}, {31'd0, 1'b1, 32'h44444444});
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_rst",
            {27'd0, dut_if.cmd_ready, dut_if.dq_oe, dut_if.dqs_oe, dut_if.dqs_o, dut_if.busy, dut_if.dq_o},
            {27'd0, 5'b10000, 32'd0});
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        cmd("t5_rcmd", 0, 6'd8); rlat("t5_pre"); rbeats("t5_rd", blk1); post("t5_post");
        add("t5_idle", 1, 0, 0, 0, 0, '0);
        run_rows();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
